move_input_ctrl: RTL and testbench

//  Front end for the 2048 game FSM. Turns the raw, bouncing, active-low push buttons into

---
 rtl/move_input_ctrl.sv | 127 ++++++++++++
 tb/tb_move_input_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: synchronizes and debounces five active-low buttons, then issues
// single-shot, mutually exclusive active-low command pulses with a lockout gap.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PULSE_CYCLES    = 2,
    parameter int LOCKOUT_CYCLES  = 50000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_start_n,
    output logic       mov_left,
    output logic       mov_right,
    output logic       mov_up,
    output logic       mov_down,
    output logic       start,
    output logic       busy,
    output logic [1:0] last_dir,
    output logic [7:0] move_count
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PULSE        = 2'd1;
    localparam logic [1:0] LOCKOUT      = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCKOUT_CYCLES - 1);

    // bit order everywhere: {start, down, up, right, left}
    logic [4:0] btn_n;
    logic [4:0] s1_q, s1_d, s2_q, s2_d;
    logic [4:0] deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [4:0] cmd_q, cmd_d;
    logic [CNT_W-1:0] db_cnt_q [5];
    logic [CNT_W-1:0] db_cnt_d [5];
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [1:0] state_q, state_d;
    logic [1:0] last_dir_q, last_dir_d;
    logic [7:0] move_count_q, move_count_d;
    logic [4:0] press, win;
    logic [1:0] win_dir;

    assign btn_n = {btn_start_n, btn_down_n, btn_up_n, btn_right_n, btn_left_n};

    always_comb begin
        s1_d = btn_n;
        s2_d = s1_q;
        deb_prev_d = deb_q;
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            db_cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) deb_d[i] = s2_q[i];
                else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign press = deb_prev_q & ~deb_q;
    assign win = press[4] ? 5'b10000 : press[0] ? 5'b00001 : press[1] ? 5'b00010 :
                 press[2] ? 5'b00100 : press[3] ? 5'b01000 : 5'b00000;
    assign win_dir = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;

    always_comb begin
        state_d = state_q;
        tmr_d = tmr_q;
        cmd_d = '1;
        last_dir_d = last_dir_q;
        move_count_d = move_count_q;
        case (state_q)
            IDLE: if (|press) begin
                state_d = PULSE;
                cmd_d = ~win;
                tmr_d = PULSE_LD;
                if (!press[4]) begin
                    last_dir_d = win_dir;
                    move_count_d = move_count_q + 8'd1;
                end
            end
            PULSE: if (tmr_q == '0) begin
                state_d = LOCKOUT;
                tmr_d = LOCK_LD;
            end else begin
                cmd_d = cmd_q;
                tmr_d = tmr_q - 1'b1;
            end
            LOCKOUT: if (tmr_q == '0) state_d = WAIT_RELEASE;
                     else tmr_d = tmr_q - 1'b1;
            default: if (&deb_q) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '1;
            s2_q <= '1;
            deb_q <= '1;
            deb_prev_q <= '1;
            cmd_q <= '1;
            for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
            tmr_q <= '0;
            state_q <= WAIT_RELEASE;
            last_dir_q <= 2'd0;
            move_count_q <= 8'd0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            deb_q <= deb_d;
            deb_prev_q <= deb_prev_d;
            cmd_q <= cmd_d;
            for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
            tmr_q <= tmr_d;
            state_q <= state_d;
            last_dir_q <= last_dir_d;
            move_count_q <= move_count_d;
        end
    end

    assign {start, mov_down, mov_up, mov_right, mov_left} = cmd_q;
    assign busy = state_q != IDLE;
    assign last_dir = last_dir_q;
    assign move_count = move_count_q;
endmodule

// File: tb/tb_move_input_ctrl.sv
// tb_move_input_ctrl: randomized and directed button stimulus, scoreboard of expected
// command pulses from an event-level reference model, checked by a separate monitor.
module tb_move_input_ctrl;
    localparam int DEB = 4, PUL = 2, LCK = 3;

    logic clk = 0, reset = 0;
    logic [4:0] btn_n = '1;
    logic mov_left, mov_right, mov_up, mov_down, start, busy;
    logic [1:0] last_dir;
    logic [7:0] move_count;
    int n_chk = 0, n_err = 0;

    move_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .LOCKOUT_CYCLES(LCK), .CNT_W(18)) dut (
        .clk(clk), .reset(reset),
        .btn_left_n(btn_n[0]), .btn_right_n(btn_n[1]), .btn_up_n(btn_n[2]),
        .btn_down_n(btn_n[3]), .btn_start_n(btn_n[4]),
        .mov_left(mov_left), .mov_right(mov_right), .mov_up(mov_up),
        .mov_down(mov_down), .start(start), .busy(busy),
        .last_dir(last_dir), .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: sync is a 2-cycle delay, a level is accepted once it has been
    // seen DEB edges in a row, and a command occupies the controller for PUL+LCK cycles
    // plus however long it takes for every button to be seen released.
    typedef struct {int cyc; int idx; int cnt; int dir;} exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc = 0;
    logic [4:0] h1, h2, m_sync, lsync, deb, pend;
    int run [5];
    int order [5] = '{4, 0, 1, 2, 3};
    int m_cnt = 0, m_dir = 0, wait_from = 0, idx;
    bit m_wait = 1;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            h1 = '1; h2 = '1; lsync = '1; deb = '1; pend = '0;
            for (int i = 0; i < 5; i++) run[i] = 0;
            m_cnt = 0; m_dir = 0; m_wait = 1; wait_from = 0;
        end else begin
            if (m_wait) begin
                if (cyc >= wait_from && deb == 5'b11111) m_wait = 0;
            end else if (pend != 0) begin
                idx = -1;
                for (int j = 0; j < 5; j++) if (idx < 0 && pend[order[j]]) idx = order[j];
                if (idx != 4) begin
                    m_cnt = (m_cnt + 1) % 256;
                    m_dir = idx;
                end
                sb.push_back('{cyc, idx, m_cnt, m_dir});
                m_wait = 1;
                wait_from = cyc + PUL + LCK + 1;
            end
            m_sync = h2; h2 = h1; h1 = btn_n;
            pend = '0;
            for (int i = 0; i < 5; i++) begin
                run[i] = (m_sync[i] == lsync[i]) ? run[i] + 1 : 1;
                if (m_sync[i] != deb[i] && run[i] >= DEB) begin
                    pend[i] = !m_sync[i];
                    deb[i] = m_sync[i];
                end
            end
            lsync = m_sync;
        end
    end

    // Monitor
    logic [4:0] cur, lowv, prev = '1;
    int plen = 0;
    int pcnt [5] = '{default: 0};
    int last_start [5] = '{default: -1};

    always @(negedge clk) begin
        cur = {start, mov_down, mov_up, mov_right, mov_left};
        lowv = ~cur;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_chk++; n_err++;
            $display("FAIL missing_pulse: cmd %0d expected at cycle %0d but no pulse occurred", sb[0].idx, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (!reset) begin
            sb.delete();
            chk("reset_cmds", cur, 31);
            chk("reset_busy", busy, 1);
            chk("reset_count", move_count, 0);
            chk("reset_dir", last_dir, 0);
            prev = '1; plen = 0;
        end else begin
            chk("one_cmd", int'($countones(lowv) <= 1), 1);
            chk("busy", busy, m_wait);
            if (cur != '1 && prev == '1) begin
                if (sb.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_pulse: outputs %b at cycle %0d, none expected", cur, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_cyc", cyc, e.cyc);
                    chk("pulse_cmd", lowv, 1 << e.idx);
                    chk("pulse_count", move_count, e.cnt);
                    chk("pulse_dir", last_dir, e.dir);
                end
                for (int i = 0; i < 5; i++) if (lowv[i]) begin
                    pcnt[i]++;
                    last_start[i] = cyc;
                end
                plen = 1;
            end else if (cur != '1) plen++;
            else if (prev != '1) chk("pulse_len", plen, PUL);
            prev = cur;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [4:0] m, input int hold, input int gap);
        btn_n = ~m;
        step(hold);
        btn_n = '1;
        step(gap);
    endtask

    int e0, mc0, p [5];
    logic [4:0] rm;

    initial begin
        step(3);
        reset = 1;
        step(5);
        // clean left press
        p = pcnt;
        btn_n = 5'b11110;
        e0 = cyc;
        step(20);
        btn_n = '1;
        step(15);
        chk("left_latency", last_start[0], e0 + 7);
        chk("left_pulses", pcnt[0] - p[0], 1);
        chk("left_count", move_count, 1);
        chk("left_dir", last_dir, 0);
        // bouncing up button
        p = pcnt;
        for (int k = 0; k < 4; k++) begin
            btn_n[2] = k[0];
            step(2);
        end
        e0 = cyc;
        btn_n[2] = 0;
        step(22);
        btn_n = '1;
        step(15);
        chk("bounce_up_pulses", pcnt[2] - p[2], 1);
        chk("bounce_up_latency", last_start[2], e0 + 7);
        // simultaneous right+down+start
        p = pcnt;
        mc0 = move_count;
        press(5'b11010, 20, 15);
        chk("simul_start", pcnt[4] - p[4], 1);
        chk("simul_right", pcnt[1] - p[1], 0);
        chk("simul_down", pcnt[3] - p[3], 0);
        chk("simul_count", move_count, mc0);
        press(5'b01000, 15, 15);
        chk("down_after", pcnt[3] - p[3], 1);
        chk("down_dir", last_dir, 3);
        // long hold gives one pulse
        p = pcnt;
        mc0 = move_count;
        press(5'b00001, 100, 15);
        chk("hold_once", pcnt[0] - p[0], 1);
        press(5'b00001, 15, 15);
        chk("hold_again", pcnt[0] - p[0], 2);
        chk("hold_count", move_count, (mc0 + 2) % 256);
        // right during lockout
        p = pcnt;
        btn_n[0] = 0;
        step(4);
        btn_n[1] = 0;
        step(4);
        chk("lock_busy_a", busy, 1);
        btn_n[0] = 1;
        step(4);
        chk("lock_busy_b", busy, 1);
        btn_n[1] = 1;
        step(20);
        chk("lock_left", pcnt[0] - p[0], 1);
        chk("lock_right", pcnt[1] - p[1], 0);
        // reset during an up pulse with the button held
        p = pcnt;
        btn_n[2] = 0;
        for (int k = 0; k < 30 && mov_up; k++) step(1);
        chk("rst_up_seen", mov_up, 0);
        reset = 0;
        #1;
        chk("rst_up_async", mov_up, 1);
        step(2);
        reset = 1;
        step(20);
        btn_n = '1;
        step(15);
        chk("rst_no_repeat", pcnt[2] - p[2], 1);
        press(5'b00100, 15, 15);
        chk("rst_repress", pcnt[2] - p[2], 2);
        // wrap of move_count
        reset = 0;
        step(2);
        reset = 1;
        step(5);
        for (int k = 0; k < 256; k++) begin
            press(k[0] ? 5'b00010 : 5'b00001, 10, 12);
            if (k == 254) chk("wrap_255", move_count, 255);
        end
        chk("wrap_count", move_count, 0);
        chk("wrap_dir", last_dir, 1);
        // random
        for (int k = 0; k < 300; k++) begin
            rm = '0;
            for (int i = 0; i < 5; i++) rm[i] = ($urandom_range(0, 3) == 0);
            btn_n = ~rm;
            step($urandom_range(1, 12));
            if ($urandom_range(0, 99) == 0) begin
                reset = 0;
                step(2);
                reset = 1;
            end
        end
        btn_n = '1;
        step(30);
        chk("sb_empty", sb.size(), 0);
        chk("final_count", move_count, m_cnt);
        chk("final_dir", last_dir, m_dir);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
